// File: rtl/ir_key_queue.sv
// ir_key_queue: validates NEC IR frames, tags held-key repeats and queues keys in a small FIFO.
module ir_key_queue #(
    parameter int         FIFO_DEPTH    = 4,
    parameter bit         ADDR_FILTER   = 1'b0,
    parameter logic [7:0] EXPECT_ADDR   = 8'h00,
    parameter int         REPEAT_WINDOW = 5_500_000,
    parameter int         CNT_W         = 23
)(
    input  logic        i_CLOCK_POS,
    input  logic        i_RESET_POS,
    input  logic        i_DATA_READY,
    input  logic [31:0] i_DATA,
    input  logic        i_READY,
    input  logic        i_OVF_CLEAR,
    output logic        o_VALID,
    output logic [16:0] o_KEY,
    output logic        o_KEY_HELD,
    output logic        o_OVERFLOW,
    output logic [7:0]  o_ERR_COUNT
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] WIN = CNT_W'(REPEAT_WINDOW);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT, CHECK, PUSH} state_t;

    state_t           r_state;
    logic             r_dr_q;
    logic [31:0]      r_data;
    logic [7:0]       r_err;
    logic [CNT_W-1:0] r_win;
    logic [15:0]      r_last;
    logic             r_held;
    logic             r_ovf;
    logic [16:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;

    logic        w_evt;
    logic        w_ok;
    logic [15:0] w_key;
    logic        w_rep;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_wr;

    assign w_evt  = i_DATA_READY && !r_dr_q;
    assign w_key  = {r_data[7:0], r_data[23:16]};
    assign w_ok   = (r_data[15:8] == ~r_data[7:0]) && (r_data[31:24] == ~r_data[23:16]) &&
                    (!ADDR_FILTER || r_data[7:0] == EXPECT_ADDR);
    assign w_rep  = (w_key == r_last) && (r_win < WIN);
    assign w_push = (r_state == PUSH);
    assign w_pop  = (r_cnt != '0) && i_READY;
    assign w_full = (r_cnt == DEPTH);
    // When full, a same-cycle pop frees the head slot that the write lands in.
    assign w_wr   = w_push && (!w_full || w_pop);

    always_ff @(posedge i_CLOCK_POS) begin
        if (i_RESET_POS) begin
            r_state <= WAIT;
            r_dr_q  <= 1'b0;
            r_data  <= '0;
            r_err   <= '0;
            r_win   <= WIN;
            r_last  <= '0;
            r_held  <= 1'b0;
            r_ovf   <= 1'b0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
        end else begin
            r_dr_q <= i_DATA_READY;
            case (r_state)
                WAIT: if (w_evt) begin
                    r_data  <= i_DATA;
                    r_state <= CHECK;
                end
                CHECK: begin
                    r_state <= w_ok ? PUSH : WAIT;
                    if (!w_ok && r_err != 8'hFF) r_err <= r_err + 8'd1;
                end
                default: r_state <= WAIT;
            endcase
            // Dropped keys still count as the last key seen for repeat tagging.
            if (w_push) begin
                r_last <= w_key;
                r_win  <= '0;
                r_held <= w_rep;
            end else if (r_win != WIN) begin
                r_win <= r_win + CNT_W'(1);
            end else begin
                r_held <= 1'b0;
            end
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_pop) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
            else if (i_OVF_CLEAR) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge i_CLOCK_POS) begin
        if (w_wr) r_mem[r_wp] <= {w_rep, w_key};
    end

    assign o_VALID     = (r_cnt != '0);
    assign o_KEY       = o_VALID ? r_mem[r_rp] : 17'h0;
    assign o_KEY_HELD  = r_held;
    assign o_OVERFLOW  = r_ovf;
    assign o_ERR_COUNT = r_err;
endmodule
